// File: rtl/mil1553_tx_arbiter.sv
// mil1553_tx_arbiter
// Shares the single 1553 encoder word stream between two message sources:
// s0 (UART command bridge) and s1 (periodic BC scheduler). Whole messages are
// granted round-robin, the encoder is allowed to finish driving the bus, and a
// minimum bus-idle gap is enforced before the next grant.
//
// Ports:
//   aclk, arstn            clock, asynchronous active-low reset
//   s0_axis_* / s1_axis_*  source word streams (tdata 16, tuser 8, tlast, tvalid, tready)
//   m_axis_*               word stream to the 1553 encoder (zero-latency mux of the owner)
//   tx_active              encoder is driving the bus (en_tx_1553)
//   grant                  one-hot current owner, 00 when nobody owns the path
//   busy                   arbiter is not idle
//   err_len                one-cycle pulse: message longer than max_words
//   err_timeout            one-cycle pulse: tx_active never rose after the last word
module mil1553_tx_arbiter #(
    parameter int unsigned clock_speed   = 2000000,
    parameter int unsigned gap_us        = 4,
    parameter int unsigned start_timeout = 64,
    parameter int unsigned max_words     = 33
) (
    input  logic        aclk,
    input  logic        arstn,

    input  logic [15:0] s0_axis_tdata,
    input  logic [7:0]  s0_axis_tuser,
    input  logic        s0_axis_tlast,
    input  logic        s0_axis_tvalid,
    output logic        s0_axis_tready,

    input  logic [15:0] s1_axis_tdata,
    input  logic [7:0]  s1_axis_tuser,
    input  logic        s1_axis_tlast,
    input  logic        s1_axis_tvalid,
    output logic        s1_axis_tready,

    output logic [15:0] m_axis_tdata,
    output logic [7:0]  m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,

    input  logic        tx_active,

    output logic [1:0]  grant,
    output logic        busy,
    output logic        err_len,
    output logic        err_timeout
);

    // Gap length in aclk cycles, never below one cycle.
    localparam int unsigned gap_raw    = (clock_speed / 1000000) * gap_us;
    localparam int unsigned gap_cycles = (gap_raw < 1) ? 1 : gap_raw;
    localparam int unsigned gap_w      = $clog2(gap_cycles + 1);
    localparam int unsigned tmo_w      = $clog2(start_timeout + 1);
    localparam int unsigned cnt_w      = $clog2(max_words + 1);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_xfer  = 2'd1;
    localparam logic [1:0] st_drain = 2'd2;
    localparam logic [1:0] st_gap   = 2'd3;

    logic [1:0]       state, state_d;
    logic [1:0]       grant_d;
    logic             ptr, ptr_d;          // 0: s0 favoured at next arbitration
    logic             started, started_d;  // drain: encoder has begun driving the bus
    logic [cnt_w-1:0] word_cnt, word_cnt_d;
    logic [tmo_w-1:0] tmo_cnt, tmo_cnt_d;
    logic [gap_w-1:0] gap_cnt, gap_cnt_d;
    logic             err_len_d, err_timeout_d;

    logic             in_xfer;
    logic             sel_s1;
    logic             handshake;
    logic             pick_s1;

    // Zero-latency word path: the owner is connected straight to the encoder.
    always_comb begin
        in_xfer        = (state == st_xfer);
        sel_s1         = grant[1];
        m_axis_tdata   = sel_s1 ? s1_axis_tdata : s0_axis_tdata;
        m_axis_tuser   = sel_s1 ? s1_axis_tuser : s0_axis_tuser;
        m_axis_tlast   = in_xfer & (sel_s1 ? s1_axis_tlast  : s0_axis_tlast);
        m_axis_tvalid  = in_xfer & (sel_s1 ? s1_axis_tvalid : s0_axis_tvalid);
        s0_axis_tready = in_xfer & grant[0] & m_axis_tready;
        s1_axis_tready = in_xfer & grant[1] & m_axis_tready;
        handshake      = m_axis_tvalid & m_axis_tready;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        grant_d       = grant;
        ptr_d         = ptr;
        started_d     = started;
        word_cnt_d    = word_cnt;
        tmo_cnt_d     = tmo_cnt;
        gap_cnt_d     = gap_cnt;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        // s1 wins when it is the only requester or when the pointer favours it.
        pick_s1       = s1_axis_tvalid & (~s0_axis_tvalid | ptr);

        case (state)
            st_idle: begin
                if (s0_axis_tvalid | s1_axis_tvalid) begin
                    grant_d    = pick_s1 ? 2'b10 : 2'b01;
                    ptr_d      = ~pick_s1;
                    word_cnt_d = '0;
                    state_d    = st_xfer;
                end
            end

            st_xfer: begin
                if (handshake) begin
                    // Saturate so an overlong message flags exactly once.
                    if (word_cnt != cnt_w'(max_words)) begin
                        word_cnt_d = word_cnt + cnt_w'(1);
                    end
                    if (!m_axis_tlast && (word_cnt == cnt_w'(max_words - 1))) begin
                        err_len_d = 1'b1;
                    end
                    if (m_axis_tlast) begin
                        started_d = 1'b0;
                        tmo_cnt_d = '0;
                        state_d   = st_drain;
                    end
                end
            end

            st_drain: begin
                if (!started) begin
                    if (tx_active) begin
                        started_d = 1'b1;
                    end else if (tmo_cnt == tmo_w'(start_timeout - 1)) begin
                        err_timeout_d = 1'b1;
                        grant_d       = 2'b00;
                        gap_cnt_d     = '0;
                        state_d       = st_gap;
                    end else begin
                        tmo_cnt_d = tmo_cnt + tmo_w'(1);
                    end
                end else if (!tx_active) begin
                    grant_d   = 2'b00;
                    gap_cnt_d = '0;
                    state_d   = st_gap;
                end
            end

            st_gap: begin
                // Any bus activity restarts the idle-gap count.
                if (tx_active) begin
                    gap_cnt_d = '0;
                end else if (gap_cnt == gap_w'(gap_cycles - 1)) begin
                    state_d = st_idle;
                end else begin
                    gap_cnt_d = gap_cnt + gap_w'(1);
                end
            end

            default: begin
                grant_d = 2'b00;
                state_d = st_idle;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state       <= st_idle;
            grant       <= 2'b00;
            ptr         <= 1'b0;
            started     <= 1'b0;
            word_cnt    <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            busy        <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            grant       <= grant_d;
            ptr         <= ptr_d;
            started     <= started_d;
            word_cnt    <= word_cnt_d;
            tmo_cnt     <= tmo_cnt_d;
            gap_cnt     <= gap_cnt_d;
            busy        <= (state_d != st_idle);
            err_len     <= err_len_d;
            err_timeout <= err_timeout_d;
        end
    end

endmodule

// File: doc/mil1553_tx_arbiter.md
Name: mil1553_tx_arbiter

Overview:
- Shares the single 1553 transmit path (encoder word stream feeding tx0/tx1/en_tx) between two message sources: s0 is the UART command bridge, s1 is the periodic bus-controller scheduler.
- Grants whole messages, never interleaved words, using round-robin priority.
- Waits for the encoder to finish driving the bus, then enforces the minimum inter-message gap before granting the next message.
- Sits between the two sources and the 1553 encoder inside the uart/1553 core, on the aclk domain.

Parameters:
- clock_speed, 2000000, aclk frequency in Hz.
- gap_us, 4, minimum bus-idle time between messages in microseconds; GAP_CYCLES = (clock_speed/1000000)*gap_us, default 8; minimum 1.
- start_timeout, 64, aclk cycles to wait for tx_active to rise after the last word is accepted.
- max_words, 33, maximum words per message (command word plus 32 data words).

Ports:
- aclk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- s0_axis_tdata  in  16  source 0 word
- s0_axis_tuser  in  8  source 0 word type/sync flags, passed through unchanged
- s0_axis_tlast  in  1  source 0 last word of message
- s0_axis_tvalid  in  1  source 0 valid
- s0_axis_tready  out  1  source 0 ready
- s1_axis_tdata / tuser / tlast / tvalid / tready  same as s0  source 1
- m_axis_tdata  out  16  word to 1553 encoder
- m_axis_tuser  out  8  word type to encoder
- m_axis_tlast  out  1  last word
- m_axis_tvalid  out  1  valid to encoder
- m_axis_tready  in  1  encoder ready
- tx_active  in  1  encoder is driving the bus (en_tx_1553)
- grant  out  2  one-hot current owner; 00 when no owner
- busy  out  1  state != IDLE
- err_len  out  1  one-cycle pulse: message exceeded max_words
- err_timeout  out  1  one-cycle pulse: tx_active did not rise within start_timeout

Behaviour:
- Reset (arstn low, asynchronous):
  - state = IDLE; grant = 00; busy = 0; err pulses = 0.
  - Priority pointer = s0 first; word counter and timers = 0.
  - All tready and m_axis_tvalid are 0 while reset is held.
- State IDLE:
  - If any tvalid is high, grant the requester favoured by the pointer; if only one requests, grant it.
  - grant is registered and becomes one-hot on the next cycle; state goes to XFER.
  - The pointer flips to the other source at each grant.
- State XFER:
  - Zero-latency combinational mux: m_axis_* = granted s_axis_*.
  - Granted tready = m_axis_tready; the non-granted tready is forced to 0.
  - Word counter increments on each handshake.
  - Handshake with tlast = 1 moves to DRAIN.
  - Handshake of word number max_words without tlast: pulse err_len, then continue passing words until tlast (no truncation).
- State DRAIN:
  - m_axis_tvalid = 0 and both tready = 0; grant is held.
  - Phase A waits for tx_active = 1. If start_timeout cycles pass first, pulse err_timeout and go to GAP.
  - Phase B waits for tx_active = 0, then goes to GAP.
  - If tx_active is already 1 on DRAIN entry, phase A completes immediately.
- State GAP:
  - grant = 00; counts GAP_CYCLES cycles with tx_active = 0.
  - If tx_active rises during GAP, the counter restarts.
  - When the count ends, return to IDLE; arbitration for the next message starts the same cycle.
- Simultaneous requests in IDLE: pointer decides. Back-to-back requests from the same source alternate with the other source whenever it is requesting.
- A source dropping tvalid mid-message is legal: the owner keeps the grant and the arbiter waits indefinitely.
- busy = (state != IDLE).
- Reset mid-message returns immediately to IDLE and discards the message. The sources must re-send it.

Test Plan:
- Single message, s0 only: 3 words 0x1234/0x0001/0x0002, tlast on word 3 -> m_axis carries the same words in order with zero added latency; grant=01 through DRAIN; after tx_active pulses 10 cycles, grant=00 for 8 cycles, then busy=0.
- Simultaneous requests, both sources with 2-word messages from reset -> s0 message completes first, then s1; no interleaved words; the gap between tx_active falling and grant=10 is at least 8 cycles.
- Fairness: s0 and s1 request continuously for 4 messages each -> grant order 01,10,01,10,... exactly.
- Backpressure: m_axis_tready toggles every cycle during a 5-word message -> all 5 words delivered intact; non-granted tready stays 0 throughout.
- Length error: 34 words with tlast on the 34th -> err_len pulses once at the 33rd handshake; all 34 words forwarded.
- Timeout and reset: tx_active held 0 after tlast -> err_timeout pulses at cycle 64, then GAP, then IDLE. Separately, arstn low mid-message -> grant=00, busy=0, tready=0 immediately.
